// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding read, small {pc, instr} FIFO,
// redirect flushes the FIFO and drops any stale in-flight response.
module fetch_unit #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        instr_enable,
  input  logic        instr_valid,
  output logic [24:0] instr_addr,
  input  logic [31:0] instr_result,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_e;

  state_e        state_q;
  logic [31:0]   pc_q;
  logic          en_q;
  logic [24:0]   addr_q;
  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [31:0]   pc_mem  [DEPTH];
  logic [31:0]   ins_mem [DEPTH];
  logic          push;
  logic          pop;
  logic [31:0]   redir_pc;
  logic          unused_lsb;

  assign redir_pc     = {redirect_pc[31:2], 2'b00};
  assign unused_lsb   = ^redirect_pc[1:0];
  assign push         = (state_q == REQ) && instr_valid && !redirect;
  assign pop          = out_valid && out_ready;
  assign out_valid    = (cnt_q != '0);
  assign out_instr    = out_valid ? ins_mem[rd_q] : '0;
  assign out_pc       = out_valid ? pc_mem[rd_q] : '0;
  assign instr_enable = en_q;
  assign instr_addr   = addr_q;

  always_comb begin
    cnt_d = cnt_q;
    if (redirect)
      cnt_d = '0;
    else if (push && !pop)
      cnt_d = cnt_q + 1'b1;
    else if (!push && pop)
      cnt_d = cnt_q - 1'b1;
  end

  // addr_q is latched separately so a redirect in DRAIN leaves it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      en_q    <= 1'b0;
      addr_q  <= RESET_PC[26:2];
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!redirect && cnt_q < FULL) begin
            state_q <= REQ;
            en_q    <= 1'b1;
            addr_q  <= pc_q[26:2];
          end
        end
        REQ: begin
          if (instr_valid) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
          end else if (redirect) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (instr_valid) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          en_q    <= 1'b0;
        end
      endcase
      if (redirect)
        pc_q <= redir_pc;
      else if (push)
        pc_q <= pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (redirect) begin
        rd_q <= '0;
        wr_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + 1'b1;
        if (pop)  rd_q <= rd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q]  <= pc_q;
      ins_mem[wr_q] <= instr_result;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model, sequential-PC reference and scoreboard.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_enable;
  logic        instr_valid = 1'b0;
  logic [24:0] instr_addr;
  logic [31:0] instr_result = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_enable(instr_enable), .instr_valid(instr_valid),
    .instr_addr(instr_addr), .instr_result(instr_result),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  int          nchk = 0;
  int          nfail = 0;
  int          cycle = 0;
  int          lat = 1;
  int          cnt = 0;
  int          nreq = 0;
  bit          pend = 0;
  bit          stale = 0;
  logic [24:0] maddr = '0;
  logic [31:0] exp_pc = RPC;
  ent_t        sb[$];
  ent_t        mon_e;
  int          req_cyc[$];
  logic [24:0] req_addr[$];
  int          pop_cyc[$];
  logic [31:0] pop_pc[$];

  function automatic logic [31:0] word(input logic [24:0] a);
    return {7'b0, a} * 32'd3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Memory with latency lat plus the reference fetch stream
  task automatic mem_step(input bit rd, input logic [31:0] rpc);
    bit got;
    got = 0;
    if (instr_valid) begin
      chk("gap", 32'(instr_enable), 32'd0);
      instr_valid = 1'b0;
    end else if (pend) begin
      chk("en_hold", 32'(instr_enable), 32'd1);
      chk("addr_hold", 32'(instr_addr), 32'(maddr));
      cnt--;
      if (cnt == 0) begin
        instr_valid  = 1'b1;
        instr_result = word(maddr);
        pend = 0;
        got  = 1;
      end
    end else if (instr_enable) begin
      pend  = 1;
      cnt   = lat;
      maddr = instr_addr;
      nreq++;
      req_cyc.push_back(cycle);
      req_addr.push_back(instr_addr);
    end
    if (got) begin
      if (!stale && !rd) begin
        chk("req_addr", 32'(maddr), 32'(exp_pc[26:2]));
        sb.push_back(ent_t'{exp_pc, word(exp_pc[26:2])});
        exp_pc = exp_pc + 32'd4;
      end
      stale = 0;
    end
    if (rd) begin
      if (pend) stale = 1;
      exp_pc = {rpc[31:2], 2'b00};
    end
  endtask

  task automatic cyc(input bit rd, input logic [31:0] rpc, input bit rdy);
    @(negedge clk);
    cycle++;
    redirect    = rd;
    redirect_pc = rpc;
    out_ready   = rdy;
    mem_step(rd, rpc);
  endtask

  task automatic do_reset(input int l);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_en", 32'(instr_enable), 32'd0);
    chk("rst_addr", 32'(instr_addr), 32'(RPC[26:2]));
    chk("rst_ovalid", 32'(out_valid), 32'd0);
    chk("rst_oinstr", out_instr, 32'd0);
    chk("rst_opc", out_pc, 32'd0);
    instr_valid = 1'b0;
    redirect    = 1'b0;
    out_ready   = 1'b0;
    pend  = 0;
    stale = 0;
    exp_pc = RPC;
    nreq = 0;
    lat  = l;
    sb.delete();
    req_cyc.delete();
    req_addr.delete();
    pop_cyc.delete();
    pop_pc.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycle = 0;
  endtask

  task automatic run_until_req(input int n, input bit rdy);
    int k;
    k = 0;
    while (nreq < n && k < 200) begin
      cyc(1'b0, '0, rdy);
      k++;
    end
    chk("req_timeout", 32'(nreq >= n), 32'd1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            nchk++;
            nfail++;
            $display("FAIL pop_empty: got pc %h want no entry", out_pc);
          end else begin
            mon_e = sb.pop_front();
            chk("out_pc", out_pc, mon_e.pc);
            chk("out_instr", out_instr, mon_e.ins);
          end
          pop_cyc.push_back(cycle);
          pop_pc.push_back(out_pc);
        end
        if (redirect) sb.delete();
      end
    end
  end

  initial begin
    int p;
    int r;
    int n0;
    int k;

    // sequential fetch, L=1
    do_reset(1);
    repeat (10) cyc(1'b0, '0, 1'b1);
    chk("req0_cyc", 32'(req_cyc[0]), 32'd1);
    chk("req1_cyc", 32'(req_cyc[1]), 32'd4);
    chk("req2_cyc", 32'(req_cyc[2]), 32'd7);
    chk("pop0_pc", pop_pc[0], 32'h0);
    chk("pop1_pc", pop_pc[1], 32'h4);
    chk("pop2_pc", pop_pc[2], 32'h8);
    chk("pop0_cyc", 32'(pop_cyc[0]), 32'd3);
    chk("pop_period", 32'(pop_cyc[1] - pop_cyc[0]), 32'd3);

    // backpressure fills the FIFO
    do_reset(1);
    repeat (20) cyc(1'b0, '0, 1'b0);
    chk("full_nreq", 32'(nreq), 32'd2);
    chk("full_en", 32'(instr_enable), 32'd0);
    chk("full_valid", 32'(out_valid), 32'd1);
    repeat (12) cyc(1'b0, '0, 1'b1);
    chk("bp_pop0", pop_pc[0], 32'h0);
    chk("bp_pop1", pop_pc[1], 32'h4);
    chk("bp_resume", 32'(req_addr[2]), 32'h2);

    // redirect with nothing outstanding, L=2
    do_reset(2);
    repeat (12) cyc(1'b0, '0, 1'b0);
    cyc(1'b1, 32'h40, 1'b0);
    n0 = cycle;
    cyc(1'b0, '0, 1'b0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    run_until_req(3, 1'b0);
    chk("redir_req_lat", 32'(req_cyc[2] - n0), 32'd2);
    chk("redir_req_addr", 32'(req_addr[2]), 32'h10);
    k = 0;
    while (!out_valid && k < 50) begin
      cyc(1'b0, '0, 1'b0);
      k++;
    end
    chk("redir_out_lat", 32'(cycle - n0), 32'(3 + lat));

    // redirect while request for pc 8 outstanding, L=4
    do_reset(4);
    run_until_req(3, 1'b1);
    chk("stale_addr", 32'(req_addr[2]), 32'h2);
    cyc(1'b1, 32'h100, 1'b1);
    #3 p = pop_pc.size();
    run_until_req(4, 1'b1);
    chk("drain_next_addr", 32'(req_addr[3]), 32'h40);
    repeat (12) cyc(1'b0, '0, 1'b1);
    chk("drain_first_pc", pop_pc[p], 32'h100);

    // redirect in the same cycle as instr_valid, L=2
    do_reset(2);
    k = 0;
    while (!(pend && cnt == 1) && k < 100) begin
      cyc(1'b0, '0, 1'b1);
      k++;
    end
    cyc(1'b1, 32'h203, 1'b1);
    #3 p = pop_pc.size();
    cyc(1'b0, '0, 1'b1);
    chk("same_empty", 32'(out_valid), 32'd0);
    r = nreq;
    run_until_req(r + 1, 1'b1);
    chk("same_next_addr", 32'(req_addr[r]), 32'h80);
    repeat (10) cyc(1'b0, '0, 1'b1);
    chk("same_first_pc", pop_pc[p], 32'h200);

    // PC wraps at 2^32
    do_reset(1);
    repeat (3) cyc(1'b0, '0, 1'b1);
    cyc(1'b1, 32'hFFFF_FFFC, 1'b1);
    #3 p = pop_pc.size();
    r = nreq;
    repeat (14) cyc(1'b0, '0, 1'b1);
    chk("wrap_addr0", 32'(req_addr[r]), 32'h01FF_FFFF);
    chk("wrap_addr1", 32'(req_addr[r+1]), 32'h0);
    chk("wrap_pc0", pop_pc[p], 32'hFFFF_FFFC);
    chk("wrap_pc1", pop_pc[p+1], 32'h0);

    // reset in the middle of a request
    run_until_req(nreq + 1, 1'b1);
    chk("pre_rst_en", 32'(instr_enable), 32'd1);
    do_reset(1);
    run_until_req(1, 1'b1);
    chk("post_rst_addr", 32'(req_addr[0]), 32'(RPC[26:2]));

    // randomized traffic
    do_reset(1 + int'($urandom % 4));
    for (int i = 0; i < 3000; i++) begin
      if (!pend && !instr_valid && ($urandom % 50) == 0)
        lat = 1 + int'($urandom % 5);
      cyc(($urandom % 20) == 0, $urandom, ($urandom % 4) != 0);
    end
    repeat (20) cyc(1'b0, '0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule
